// File: rtl/unified_mem_pkg.sv
// Shared definitions for unified_mem: access-size encodings, byte-enable
// generation and load extraction/extension.
package unified_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // The lane is expected to be already aligned for half/word accesses.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: load_extend = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/unified_mem_array.sv
// Word array with synchronous read and per-byte write enables; contents
// are not reset.
module unified_mem_array #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/unified_mem.sv
// Single-port unified instruction/data memory with fixed data-port priority.
// Define UNIFIED_MEM_MISALIGN_TRAP_EN to trap misaligned data accesses via d_err.
module unified_mem
  import unified_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          mis;
  logic [31:0]   wdata_rep;
  logic          arr_we;
  logic [31:0]   arr_rdata;
  logic [1:0]    lane_q, size_q;
  logic          uns_q;
  logic [31:0]   i_last, d_last;
  logic          unused_addr;

  assign unused_addr = ^{i_addr[ADDR_W-1:AW+2], i_addr[1:0], d_addr[ADDR_W-1:AW+2]};

  assign d_gnt = d_req;
  assign i_gnt = i_req & ~d_req;
  assign idx   = d_req ? d_addr[AW+1:2] : i_addr[AW+1:2];

  always_comb begin
    lane      = d_addr[1:0];
    wdata_rep = d_wdata;
    case (d_size)
      SZ_BYTE: wdata_rep = {4{d_wdata[7:0]}};
      SZ_HALF: begin
        lane      = {d_addr[1], 1'b0};
        wdata_rep = {2{d_wdata[15:0]}};
      end
      default: lane = 2'b00;
    endcase
  end

`ifdef UNIFIED_MEM_MISALIGN_TRAP_EN
  logic d_err_q;

  always_comb begin
    case (d_size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = d_addr[0];
      default: mis = |d_addr[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) d_err_q <= 1'b0;
    else        d_err_q <= d_req & mis;
  end

  assign d_err = d_err_q;
`else
  assign mis   = 1'b0;
  assign d_err = 1'b0;
`endif

  assign arr_we = rst_n & d_req & d_we & ~mis;

  unified_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (byte_en(d_size, lane)),
    .idx   (idx),
    .wdata (wdata_rep),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      lane_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      i_last   <= '0;
      d_last   <= '0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_req & ~d_we & ~mis;
      i_last   <= i_rdata;
      d_last   <= d_rdata;
      if (d_req) begin
        lane_q <= lane;
        size_q <= d_size;
        uns_q  <= d_unsigned;
      end
    end
  end

  // The array read register is shared by both ports, so each port keeps its
  // own copy of the last delivered value to hold while idle.
  assign i_rdata = i_rvalid ? arr_rdata : i_last;
  assign d_rdata = d_rvalid ? load_extend(arr_rdata, size_q, lane_q, uns_q) : d_last;

endmodule

// File: tb/tb_unified_mem.sv
// Directed self-checking bench for unified_mem: vector table plus hand
// sequences for arbitration, misalignment and reset.
module tb_unified_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  unified_mem #(.DEPTH(256), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dreq, we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wdata;
    logic        ireq;
    logic [31:0] iaddr;
    logic        eig, edg, edrv;
    logic [31:0] edrd;
    logic        eirv;
    logic [31:0] eird;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic dreq, logic we, logic [1:0] sz, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic ireq, logic [31:0] iaddr, logic eig,
                              logic edg, logic edrv, logic [31:0] edrd, logic eirv, logic [31:0] eird);
    vec_t v;
    v.dreq = dreq; v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.ireq = ireq; v.iaddr = iaddr; v.eig = eig; v.edg = edg; v.edrv = edrv; v.edrd = edrd;
    v.eirv = eirv; v.eird = eird;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dreq, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic ireq,
                       input logic [31:0] iaddr);
    @(negedge clk);
    d_req = dreq; d_we = we; d_size = sz; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
    i_req = ireq; i_addr = iaddr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rst_d_err",    {31'b0, d_err},    32'h0);
    chk("rst_i_rdata",  i_rdata, 32'h0);
    chk("rst_d_rdata",  d_rdata, 32'h0);

    //             dreq we  sz     uns  addr      wdata       ireq iaddr  ig dg drv drd         irv ird
    tbl.push_back(mk(1, 1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,   0, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h10,  32'h0,        0, 32'h0,   0, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h0,   32'h0,        1, 32'h10,  1, 0, 1, 32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b10, 0, 32'h20,  32'h80FF7F01, 0, 32'h0,   0, 1, 0, 32'h0,        1, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 2'b00, 0, 32'h23,  32'h0,        0, 32'h0,   0, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 32'h23,  32'h0,        0, 32'h0,   0, 1, 1, 32'hFFFFFF80, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 32'h22,  32'h0,        0, 32'h0,   0, 1, 1, 32'h00000080, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b10, 0, 32'h8,   32'h11223344, 0, 32'h0,   0, 1, 1, 32'hFFFFFFFF, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b01, 0, 32'hA,   32'h0000ABCD, 0, 32'h0,   0, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h8,   32'h0,        0, 32'h0,   0, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b01, 0, 32'hA,   32'h0,        0, 32'h0,   0, 1, 1, 32'hABCD3344, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b01, 1, 32'hA,   32'h0,        0, 32'h0,   0, 1, 1, 32'hFFFFABCD, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b00, 0, 32'h21,  32'h1234565A, 0, 32'h0,   0, 1, 1, 32'h0000ABCD, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h20,  32'h0,        0, 32'h0,   0, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 1, 32'h80FF5A01, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b10, 0, 32'h400, 32'h5,        0, 32'h0,   0, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h0,   32'h0,        0, 32'h0,   0, 1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h0,   32'h0,        1, 32'h403, 1, 0, 1, 32'h00000005, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2'b11, 0, 32'h10,  32'h0,        0, 32'h0,   0, 1, 0, 32'h0,        1, 32'h00000005));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 1, 32'hDEADBEEF, 0, 32'h0));

    rst_n = 1'b1;
    foreach (tbl[k]) begin
      drive(tbl[k].dreq, tbl[k].we, tbl[k].sz, tbl[k].uns, tbl[k].addr, tbl[k].wdata,
            tbl[k].ireq, tbl[k].iaddr);
      chk($sformatf("v%0d_i_gnt", k),    {31'b0, i_gnt},    {31'b0, tbl[k].eig});
      chk($sformatf("v%0d_d_gnt", k),    {31'b0, d_gnt},    {31'b0, tbl[k].edg});
      chk($sformatf("v%0d_d_rvalid", k), {31'b0, d_rvalid}, {31'b0, tbl[k].edrv});
      chk($sformatf("v%0d_i_rvalid", k), {31'b0, i_rvalid}, {31'b0, tbl[k].eirv});
      chk($sformatf("v%0d_d_err", k),    {31'b0, d_err},    32'h0);
      if (tbl[k].edrv) chk($sformatf("v%0d_d_rdata", k), d_rdata, tbl[k].edrd);
      if (tbl[k].eirv) chk($sformatf("v%0d_i_rdata", k), i_rdata, tbl[k].eird);
    end
    idle();
    chk("hold_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("hold_i_rdata", i_rdata, 32'h00000005);

`ifdef UNIFIED_MEM_MISALIGN_TRAP_EN
    drive(1, 1, 2'b10, 0, 32'h4, 32'h12345678, 0, 32'h0);
    drive(1, 1, 2'b10, 0, 32'h6, 32'hFFFFFFFF, 0, 32'h0);
    drive(1, 0, 2'b10, 0, 32'h4, 32'h0, 0, 32'h0);
    chk("mis_sw_err", {31'b0, d_err}, 32'h1);
    drive(1, 0, 2'b01, 0, 32'h5, 32'h0, 0, 32'h0);
    chk("mis_lw_err", {31'b0, d_err}, 32'h0);
    chk("mis_lw_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("mis_lw_data", d_rdata, 32'h12345678);
    idle();
    chk("mis_lh_err", {31'b0, d_err}, 32'h1);
    chk("mis_lh_rvalid", {31'b0, d_rvalid}, 32'h0);
    idle();
    chk("mis_err_pulse", {31'b0, d_err}, 32'h0);
`else
    drive(1, 1, 2'b01, 0, 32'hB, 32'h00007777, 0, 32'h0);
    drive(1, 0, 2'b01, 0, 32'h9, 32'h0, 0, 32'h0);
    drive(1, 0, 2'b10, 0, 32'hB, 32'h0, 0, 32'h0);
    chk("una_lh_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("una_lh_data", d_rdata, 32'h00003344);
    idle();
    chk("una_lw_data", d_rdata, 32'h77773344);
    chk("una_err", {31'b0, d_err}, 32'h0);
`endif

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2'b10, 0, 32'h4, 32'h0, 1, 32'h10);
      chk($sformatf("arb%0d_i_gnt", i), {31'b0, i_gnt}, 32'h0);
      chk($sformatf("arb%0d_d_gnt", i), {31'b0, d_gnt}, 32'h1);
      chk($sformatf("arb%0d_i_rvalid", i), {31'b0, i_rvalid}, 32'h0);
    end
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0, 1, 32'h10);
    chk("arb3_i_gnt", {31'b0, i_gnt}, 32'h1);
    chk("arb3_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("arb3_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    idle();
    chk("arb4_i_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("arb4_i_rdata", i_rdata, 32'hDEADBEEF);

    drive(1, 0, 2'b10, 0, 32'h0, 32'h0, 1, 32'h0);
    rst_n = 1'b0;
    drive(1, 1, 2'b10, 0, 32'h0, 32'h00000099, 0, 32'h0);
    chk("rst_lw_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rst2_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rst2_d_rdata", d_rdata, 32'h0);
    chk("rst2_i_rdata", i_rdata, 32'h0);
    drive(1, 0, 2'b10, 0, 32'h0, 32'h0, 0, 32'h0);
    rst_n = 1'b1;
    chk("rst_sw_rvalid", {31'b0, d_rvalid}, 32'h0);
    idle();
    chk("post_rst_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("post_rst_data", d_rdata, 32'h00000005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
